// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the parametrised Fibonacci LFSR:
//   - LFSR_TAPS_TABLE : maximal-length feedback masks for widths 3..32
//   - lfsr_nxt()      : one right shift with the XOR feedback entering the MSB
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_MIN_WIDTH = 3;
   localparam int LFSR_MAX_WIDTH = 32;

   // Entry [w-3] is the feedback mask for a w-bit register. Bit i set means
   // state bit i feeds the XOR. With the shift running towards bit 0, a mask
   // with bits {0, w-k} realises the primitive trinomial/pentanomial family
   // x^w + x^k + 1 (bit 0 is always tapped so the map is invertible).
   localparam logic [29:0][31:0] LFSR_TAPS_TABLE = {
      32'hC000_0401,  // 32
      32'h0000_0009,  // 31
      32'h2500_0001,  // 30
      32'h0000_0005,  // 29
      32'h0000_0009,  // 28
      32'h0640_0001,  // 27
      32'h0310_0001,  // 26
      32'h0000_0009,  // 25
      32'h0000_0087,  // 24
      32'h0000_0021,  // 23
      32'h0000_0003,  // 22
      32'h0000_0005,  // 21
      32'h0000_0009,  // 20
      32'h0006_2001,  // 19
      32'h0000_0081,  // 18
      32'h0000_0009,  // 17
      32'h0000_100B,  // 16
      32'h0000_0003,  // 15
      32'h0000_2A01,  // 14
      32'h0000_1601,  // 13
      32'h0000_0941,  // 12
      32'h0000_0005,  // 11
      32'h0000_0009,  // 10
      32'h0000_0011,  // 9
      32'h0000_001D,  // 8
      32'h0000_0003,  // 7
      32'h0000_0003,  // 6
      32'h0000_0005,  // 5
      32'h0000_0003,  // 4
      32'h0000_0003   // 3
   };

   // One Fibonacci shift. The caller passes the state zero-extended to 32
   // bits, so the right shift never pulls garbage into the live field.
   function automatic logic [31:0] lfsr_nxt(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
      logic fb;
      fb = ^(state & taps);
      return (state >> 1) | ({31'd0, fb} << (width - 1));
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Purely combinational chain of STEPS single-shift stages.
// Ports:
//   i_state    in  WIDTH  state before this cycle's shifts
//   o_state    out WIDTH  state after STEPS shifts
//   o_seed_hit out 1      some stage output s1..sSTEPS equals SEED
// -----------------------------------------------------------------------------
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_TABLE[WIDTH-LFSR_MIN_WIDTH]),
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int               STEPS = 1
) (
   input  logic [WIDTH-1:0] i_state,
   output logic [WIDTH-1:0] o_state,
   output logic             o_seed_hit
);

   logic [WIDTH-1:0] w_stage [STEPS+1];
   logic [STEPS-1:0] w_hit;

   assign w_stage[0] = i_state;

   for (genvar g = 0; g < STEPS; g++) begin : g_stage
      assign w_stage[g+1] = WIDTH'(lfsr_nxt(32'(w_stage[g]), 32'(TAPS), WIDTH));
      // The start state s0 is deliberately excluded: only states reached by
      // this cycle's shifts count as returning to SEED.
      assign w_hit[g] = (w_stage[g+1] == SEED);
   end

   assign o_state    = w_stage[STEPS];
   assign o_seed_hit = |w_hit;

endmodule

// File: rtl/lfsr_param.sv
// -----------------------------------------------------------------------------
// lfsr_param
// Parametrised Fibonacci LFSR with seed load, step enable, STEPS shifts per
// enabled cycle, period-wrap pulse and enabled-cycle counter.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      asynchronous, active-low
//   en        in  1      advance STEPS shifts this cycle
//   load      in  1      synchronous seed load, wins over en
//   load_val  in  WIDTH  seed for load (zero is replaced by SEED)
//   q         out WIDTH  current state, registered
//   bit_out   out 1      q[0]
//   wrap      out 1      one-cycle pulse when SEED was reached this update
//   step_cnt  out WIDTH  enabled cycles since reset/load/wrap
// WIDTH valid range 3..32, STEPS 1..WIDTH, SEED non-zero.
// -----------------------------------------------------------------------------
module lfsr_param
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_TABLE[WIDTH-LFSR_MIN_WIDTH]),
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int               STEPS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH-1:0] step_cnt
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;

   logic [WIDTH-1:0] w_step_q;
   logic             w_seed_hit;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_wrap_nxt;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED),
      .STEPS (STEPS)
   ) u_step (
      .i_state    (r_q),
      .o_state    (w_step_q),
      .o_seed_hit (w_seed_hit)
   );

   // Next-state selection: load beats en, idle holds q/step_cnt and clears wrap.
   always_comb begin
      w_q_nxt    = r_q;
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;
      if (load) begin
         // A zero seed would lock the register up; substitute SEED.
         w_q_nxt   = (load_val == ZERO) ? SEED : load_val;
         w_cnt_nxt = ZERO;
      end else if (en) begin
         if (r_q == ZERO) begin
            // Lock-up cannot arise by construction; recover anyway.
            w_q_nxt   = SEED;
            w_cnt_nxt = ZERO;
         end else begin
            w_q_nxt    = w_step_q;
            w_wrap_nxt = w_seed_hit;
            w_cnt_nxt  = w_seed_hit ? ZERO : (r_cnt + ONE);
         end
      end else begin
         w_q_nxt = r_q;
      end
   end

   // State, counter and wrap registers with asynchronous reset to SEED.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q    <= SEED;
         r_cnt  <= ZERO;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_cnt  <= w_cnt_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign q        = r_q;
   assign bit_out  = r_q[0];
   assign wrap     = r_wrap;
   assign step_cnt = r_cnt;

endmodule
